fixed_to_float: RTL and testbench

- Iterative converter from signed two's-complement fixed-point to IEEE-754 single precision.
- Binary point position is supplied per transaction.
- Complement of the float-to-fixed path: feeds fixed-point datapath results back to float consumers.
- Normalises one bit per clock; valid/ready handshake on both sides.

---
 rtl/fixed_float_pkg.sv | 15 +
 rtl/fixed_to_float.sv | 93 +++++++++
 tb/tb_fixed_to_float.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fixed_float_pkg.sv
// Shared definitions for the fixed<->float converters: FSM states and IEEE single constants.
package fixed_float_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } f2f_state_e;

  localparam int          BIAS       = 127;
  localparam int          EXP_BASE   = 158;   // BIAS + 31 for a 32-bit integer part
  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fixed_to_float.sv
// Signed fixed-point to IEEE-754 single converter; normalises one bit per clock
// with a shift loop and truncates the mantissa toward zero.
module fixed_to_float #(
  parameter int WIDTH = 32,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] fixed,
  input  logic [4:0]       fixpointpos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result
);
  import fixed_float_pkg::*;

  // Exponent of a value whose MSB sits at bit WIDTH-1 with no fractional bits.
  localparam logic [8:0] EXP_INIT = 9'(BIAS + WIDTH - 1);

  f2f_state_e       state_q, state_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [8:0]       exp_q, exp_d;
  logic [31:0]      result_q, result_d;
  logic             out_valid_q, out_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      result_q    <= FLOAT_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // The most negative input negates to itself, which is the correct unsigned magnitude.
          sign_d  = fixed[WIDTH-1];
          mag_d   = fixed[WIDTH-1] ? (~fixed + WIDTH'(1)) : fixed;
          exp_d   = EXP_INIT - {4'b0000, fixpointpos};
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0 || mag_q[WIDTH-1]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 9'd1;
        end
      end
      PACK: begin
        // Exponent range is 96..158 here, so the low 8 bits are always the biased exponent.
        if (mag_q == '0) result_d = FLOAT_ZERO;
        else             result_d = {sign_q, exp_q[7:0], mag_q[WIDTH-2 -: 23]};
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Randomised and directed bench for fixed_to_float against a real-arithmetic reference.
module tb_fixed_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fixed;
  logic [4:0]  fixpointpos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  fixed_to_float #(.WIDTH(32), .BIAS(127)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fixed       (fixed),
    .fixpointpos (fixpointpos),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Value = signed(f) / 2^p computed in double precision (exact for 32-bit inputs),
  // then narrowed to single by dropping low mantissa bits.
  function automatic logic [31:0] ref_float(input logic [31:0] f, input logic [4:0] p,
                                            output int lz);
    real         v;
    logic [63:0] b;
    int          ue;
    if (f == 32'h0) begin
      lz = 0;
      return 32'h0;
    end
    v = $itor($signed(f));
    for (int i = 0; i < int'(p); i++) v = v / 2.0;
    b  = $realtobits(v);
    ue = int'(b[62:52]) - 1023;
    lz = 31 - (ue + int'(p));
    return {b[63], 8'(ue + 127), b[51:29]};
  endfunction

  task automatic run(input logic [31:0] f, input logic [4:0] p, input int stall,
                     input bit poke, input string tag);
    int          lz, lat, n;
    bit          got;
    logic [31:0] expr;
    expr = ref_float(f, p, lz);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; fixed = f; fixpointpos = p;
    @(posedge clk); #1;
    in_valid = 1'b0; fixed = $urandom; fixpointpos = 5'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      if (poke && lat == 4) begin
        in_valid = 1'b1; fixed = ~f; fixpointpos = p + 5'd3;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      got = out_valid;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(2 + lz));
    chk({tag, " result"}, result, expr);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, " stall result"}, result, expr);
      chk({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    chk({tag, " result kept"}, result, expr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fixed = '0; fixpointpos = '0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run(32'h0000_0001, 5'd0,  0, 1'b1, "one");
    chk("one const", result, 32'h3F80_0000);
    run(32'h0000_0180, 5'd8,  0, 1'b0, "1p5");
    chk("1p5 const", result, 32'h3FC0_0000);
    run(32'hFFFF_FFFE, 5'd0,  5, 1'b1, "neg2");
    chk("neg2 const", result, 32'hC000_0000);
    run(32'h8000_0000, 5'd31, 0, 1'b0, "minint");
    chk("minint const", result, 32'hBF80_0000);
    run(32'h0000_0000, 5'd13, 2, 1'b0, "zero");
    run(32'h0100_0001, 5'd0,  0, 1'b0, "trunc");
    chk("trunc const", result, 32'h4B80_0000);
    run(32'h7FFF_FFFF, 5'd0,  0, 1'b0, "maxpos");

    for (int k = 0; k < 40; k++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = -r;
      run(r, 5'($urandom_range(0, 31)), $urandom_range(0, 3), 1'b0, $sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of normalisation.
    in_valid = 1'b1; fixed = 32'h0000_0001; fixpointpos = 5'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset result", result, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    run(32'h0000_0002, 5'd1, 0, 1'b0, "postreset");
    chk("postreset const", result, 32'h3F80_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
